// File: rtl/riscv_dp_lsu.sv
// Memory-stage load/store unit driving a req/gnt/rvalid data bus and stalling the pipeline.
// Optional RISCV_LSU_MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and flag omisalign.
module riscv_dp_lsu #(
    parameter int unsigned MP_DATA_WIDTH = 32,
    parameter int unsigned MP_ADDR_WIDTH = 32
) (
    input  logic                     iclk,
    input  logic                     irst,
    input  logic                     ivalid,
    input  logic                     iwe,
    input  logic [2:0]               ifunct3,
    input  logic [MP_ADDR_WIDTH-1:0] iaddr,
    input  logic [MP_DATA_WIDTH-1:0] iwdata,
    output logic                     ostall,
    output logic                     odone,
    output logic [MP_DATA_WIDTH-1:0] ordata,
    output logic [1:0]               ooffset,
    output logic                     omisalign,
    output logic                     omem_req,
    output logic                     omem_we,
    output logic [MP_ADDR_WIDTH-1:0] omem_addr,
    output logic [3:0]               omem_be,
    output logic [MP_DATA_WIDTH-1:0] omem_wdata,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [MP_DATA_WIDTH-1:0] imem_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e                   state_q, state_d;
    logic [MP_ADDR_WIDTH-1:0] addr_q;
    logic [3:0]               be_q;
    logic [MP_DATA_WIDTH-1:0] wdata_q;
    logic                     we_q;
    logic [1:0]               off_q;
    logic [MP_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]               roff_q;

    logic [1:0]               off;
    logic [3:0]               be_calc;
    logic [MP_DATA_WIDTH-1:0] wdata_calc;
    logic                     mis_calc;
    logic                     unused_funct3;

    assign off           = iaddr[1:0];
    assign unused_funct3 = ifunct3[2];

    // Byte and half rotate across all four lanes; half at offset 3 wraps to lanes 3 and 0.
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = iwdata;
        if (ifunct3[1] == 1'b0) begin
            unique case (off)
                2'd0: wdata_calc = iwdata;
                2'd1: wdata_calc = {iwdata[23:0], iwdata[31:24]};
                2'd2: wdata_calc = {iwdata[15:0], iwdata[31:16]};
                2'd3: wdata_calc = {iwdata[7:0],  iwdata[31:8]};
                default: wdata_calc = iwdata;
            endcase
            if (ifunct3[0] == 1'b0) begin
                be_calc = 4'b0001 << off;
            end else begin
                unique case (off)
                    2'd0: be_calc = 4'b0011;
                    2'd1: be_calc = 4'b0110;
                    2'd2: be_calc = 4'b1100;
                    2'd3: be_calc = 4'b1001;
                    default: be_calc = 4'b0011;
                endcase
            end
        end
    end

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    logic mis_q;

    assign mis_calc  = (ifunct3[1:0] == 2'b01 && off == 2'd3) || (ifunct3[1] && off != 2'd0);
    assign omisalign = (state_q == StDone) && mis_q;

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            mis_q <= 1'b0;
        end else if (state_q == StIdle && ivalid) begin
            mis_q <= mis_calc;
        end
    end
`else
    assign mis_calc  = 1'b0;
    assign omisalign = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (ivalid) state_d = mis_calc ? StDone : StReq;
            StReq:  if (imem_gnt) state_d = we_q ? StDone : StWait;
            StWait: if (imem_rvalid) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            off_q   <= '0;
            rdata_q <= '0;
            roff_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && ivalid) begin
                addr_q  <= {iaddr[MP_ADDR_WIDTH-1:2], 2'b00};
                be_q    <= be_calc;
                wdata_q <= wdata_calc;
                we_q    <= iwe;
                off_q   <= off;
            end
            if (state_q == StWait && imem_rvalid) begin
                rdata_q <= imem_rdata;
                roff_q  <= off_q;
            end
        end
    end

    assign omem_req   = (state_q == StReq);
    assign omem_we    = (state_q == StReq) && we_q;
    assign omem_addr  = addr_q;
    assign omem_be    = be_q;
    assign omem_wdata = wdata_q;
    assign odone      = (state_q == StDone);
    assign ostall     = ivalid && (state_q != StDone);
    assign ordata     = rdata_q;
    assign ooffset    = roff_q;

endmodule

// File: tb/tb_riscv_dp_lsu.sv
// Self-checking bench for riscv_dp_lsu: directed scenarios plus randomized ops against a
// cycle-count and byte-lane reference model.
module tb_riscv_dp_lsu;

    logic        iclk = 1'b0;
    logic        irst;
    logic        ivalid;
    logic        iwe;
    logic [2:0]  ifunct3;
    logic [31:0] iaddr;
    logic [31:0] iwdata;
    logic        ostall;
    logic        odone;
    logic [31:0] ordata;
    logic [1:0]  ooffset;
    logic        omisalign;
    logic        omem_req;
    logic        omem_we;
    logic [31:0] omem_addr;
    logic [3:0]  omem_be;
    logic [31:0] omem_wdata;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_rdata = '0;
    logic [1:0]  exp_off   = '0;

    always #5 iclk = ~iclk;

    riscv_dp_lsu #(
        .MP_DATA_WIDTH(32),
        .MP_ADDR_WIDTH(32)
    ) u_dut (
        .iclk       (iclk),
        .irst       (irst),
        .ivalid     (ivalid),
        .iwe        (iwe),
        .ifunct3    (ifunct3),
        .iaddr      (iaddr),
        .iwdata     (iwdata),
        .ostall     (ostall),
        .odone      (odone),
        .ordata     (ordata),
        .ooffset    (ooffset),
        .omisalign  (omisalign),
        .omem_req   (omem_req),
        .omem_we    (omem_we),
        .omem_addr  (omem_addr),
        .omem_be    (omem_be),
        .omem_wdata (omem_wdata),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic int lane_shift(input logic [2:0] f3, input logic [31:0] addr);
        return (nbytes(f3) == 4) ? 0 : int'(addr % 4);
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] be = '0;
        int o = lane_shift(f3, addr);
        for (int i = 0; i < nbytes(f3); i++) be[(o + i) % 4] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] d);
        logic [31:0] w = '0;
        int o = lane_shift(f3, addr);
        for (int i = 0; i < 4; i++) w[8 * ((i + o) % 4) +: 8] = d[8 * i +: 8];
        return w;
    endfunction

    function automatic bit ref_trap(input logic [2:0] f3, input logic [31:0] addr);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
        return (nbytes(f3) == 2 && addr % 4 == 3) || (nbytes(f3) == 4 && addr % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    // gd: REQ cycles before grant; rd: WAIT cycles before rvalid. Spurious rvalid with junk
    // data is driven in IDLE, REQ (including the grant cycle) and DONE.
    task automatic do_op(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int gd, input int rd,
                         input logic [31:0] rdata, input bit hold);
        bit trap = ref_trap(f3, addr);
        int cd   = trap ? 1 : (we ? 2 + gd : 3 + gd + rd);
        @(negedge iclk);
        ivalid  = 1'b1;
        iwe     = we;
        ifunct3 = f3;
        iaddr   = addr;
        iwdata  = wd;
        for (int c = 0; c <= cd; c++) begin
            bit in_req = !trap && c >= 1 && c <= 1 + gd;
            imem_gnt = (c == 0) ? 1'($urandom % 2) : (in_req && c == 1 + gd);
            if (!we && !trap && c == 2 + gd + rd) begin
                imem_rvalid = 1'b1;
                imem_rdata  = rdata;
            end else if (in_req || c == 0 || c == cd) begin
                imem_rvalid = 1'($urandom % 2);
                imem_rdata  = $urandom;
            end else begin
                imem_rvalid = 1'b0;
            end
            #1;
            check("req", 32'(omem_req), 32'(in_req));
            check("done", 32'(odone), 32'(c == cd));
            check("stall", 32'(ostall), 32'(c != cd));
            if (in_req) begin
                check("addr", omem_addr, addr & 32'hFFFF_FFFC);
                check("be", 32'(omem_be), 32'(ref_be(f3, addr)));
                check("wdata", omem_wdata, ref_wdata(f3, addr, wd));
                check("we", 32'(omem_we), 32'(we));
            end
            if (c == cd) begin
                if (!we && !trap) begin
                    exp_rdata = rdata;
                    exp_off   = addr[1:0];
                end
                check("misalign", 32'(omisalign), 32'(trap));
                check("rdata", ordata, exp_rdata);
                check("offset", 32'(ooffset), 32'(exp_off));
                if (!hold) ivalid = 1'b0;
            end else begin
                @(negedge iclk);
            end
        end
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
    endtask

    initial begin
        irst        = 1'b1;
        ivalid      = 1'b0;
        iwe         = 1'b0;
        ifunct3     = 3'd0;
        iaddr       = '0;
        iwdata      = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        repeat (2) @(negedge iclk);
        #1;
        check("rst_req", 32'(omem_req), 0);
        check("rst_we", 32'(omem_we), 0);
        check("rst_done", 32'(odone), 0);
        check("rst_mis", 32'(omisalign), 0);
        check("rst_addr", omem_addr, 0);
        check("rst_be", 32'(omem_be), 0);
        check("rst_wdata", omem_wdata, 0);
        check("rst_rdata", ordata, 0);
        check("rst_off", 32'(ooffset), 0);
        check("rst_stall", 32'(ostall), 0);
        irst = 1'b0;

        do_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, 1'b0);
        do_op(1'b1, 3'b000, 32'h103, 32'h000000A5, 1, 0, 32'h0, 1'b0);
        do_op(1'b0, 3'b010, 32'h102, 32'h0, 3, 1, 32'h12345678, 1'b0);
        do_op(1'b1, 3'b001, 32'h207, 32'h0000BEEF, 0, 0, 32'h0, 1'b0);

        // Reset while waiting for read data, then a stray rvalid that must be ignored.
        @(negedge iclk);
        ivalid  = 1'b1;
        iwe     = 1'b0;
        ifunct3 = 3'b010;
        iaddr   = 32'h300;
        @(negedge iclk);
        imem_gnt = 1'b1;
        @(negedge iclk);
        imem_gnt = 1'b0;
        #1;
        check("wait_req", 32'(omem_req), 0);
        irst = 1'b1;
        #1;
        check("mid_rst_req", 32'(omem_req), 0);
        check("mid_rst_done", 32'(odone), 0);
        exp_rdata = '0;
        exp_off   = '0;
        ivalid    = 1'b0;
        @(negedge iclk);
        irst        = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0BAD0;
        @(negedge iclk);
        imem_rvalid = 1'b0;
        #1;
        check("post_rst_done", 32'(odone), 0);
        check("post_rst_rdata", ordata, exp_rdata);
        do_op(1'b0, 3'b000, 32'h301, 32'h0, 0, 0, 32'hCAFEF00D, 1'b0);

        // Back-to-back with ivalid held.
        do_op(1'b0, 3'b001, 32'h402, 32'h0, 1, 0, 32'h55AA33CC, 1'b1);
        do_op(1'b1, 3'b011, 32'h404, 32'h87654321, 0, 0, 32'h0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            do_op(1'($urandom % 2), 3'($urandom % 8), $urandom, $urandom,
                  int'($urandom % 4), int'($urandom % 4), $urandom, 1'($urandom % 2));
        end
        ivalid = 1'b0;
        repeat (2) @(negedge iclk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
